// File: rtl/readout_seq_v2_if.sv
// Bus between the exposure controller and the row-readout sequencer.
// RO_FRAME_CNT_EN adds the frame_cnt return signal.
interface readout_seq_v2_if #(
  parameter int ROW_W = 10,
  parameter int TW    = 16
);
  logic             trigger_i;
  logic [TW-1:0]    T1;
  logic [TW-1:0]    T2;
  logic [TW-1:0]    T3;
  logic [TW-1:0]    T4;
  logic [TW-1:0]    T5;
  logic [TW-1:0]    T6;
  logic [ROW_W:0]   NUM_ROW;
  logic [ROW_W-1:0] ROW_START;
  logic [ROW_W-1:0] ROW_STRIDE;
  logic             re_busy;
  logic [ROW_W-1:0] ROWADD;
  logic             COL_L_EN;
  logic             COL_PRECH;
  logic             MUX_START;
  logic             CP_MUX_IN;
  logic             frame_done;
`ifdef RO_FRAME_CNT_EN
  logic [15:0]      frame_cnt;
`endif

  modport master (
    output trigger_i, T1, T2, T3, T4, T5, T6,
    output NUM_ROW, ROW_START, ROW_STRIDE,
    input  re_busy, ROWADD, COL_L_EN, COL_PRECH,
    input  MUX_START, CP_MUX_IN, frame_done
`ifdef RO_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

  modport slave (
    input  trigger_i, T1, T2, T3, T4, T5, T6,
    input  NUM_ROW, ROW_START, ROW_STRIDE,
    output re_busy, ROWADD, COL_L_EN, COL_PRECH,
    output MUX_START, CP_MUX_IN, frame_done
`ifdef RO_FRAME_CNT_EN
    , output frame_cnt
`endif
  );
endinterface

// File: rtl/readout_seq_v2.sv
// Row-readout timing sequencer: row window stepping plus per-row strobes.
// Optional macro RO_FRAME_CNT_EN adds a 16-bit completed-frame counter.
module readout_seq_v2 #(
  parameter int ROW_W = 10,
  parameter int TW    = 16,
  parameter int N_MUX = 1
) (
  input logic              CLK,
  input logic              rst,
  readout_seq_v2_if.slave  bus
);
  localparam int CW = TW + 8;
  localparam logic [ROW_W:0] R_ONE = 1;
  localparam logic [TW-1:0]  T_ONE = 1;

  typedef enum logic {IDLE, ROW} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    t_q, t_d;
  logic [ROW_W:0]   r_q, r_d;
  logic [ROW_W-1:0] rowadd_q, rowadd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [TW-1:0]    tlast_q, tlast_d;
  logic [TW-1:0]    t2_q, t2_d;
  logic [TW-1:0]    t3_q, t3_d;
  logic [TW-1:0]    t4_q, t4_d;
  logic [TW-1:0]    t5_q, t5_d;
  logic [TW-1:0]    t6_q, t6_d;
  logic [ROW_W:0]   nrow_q, nrow_d;
  logic [ROW_W-1:0] stride_q, stride_d;
  logic             col_l_q, col_l_d;
  logic             prech_q, prech_d;
  logic             mux_q, mux_d;
  logic             cp_q, cp_d;
  logic [CW-1:0]    pend_q, pend_d;
  logic [7:0]       left_q, left_d;
`ifdef RO_FRAME_CNT_EN
  logic [15:0]      fcnt_q, fcnt_d;
`endif

  logic             run;
  logic             start;
  logic             hit;
  logic [CW-1:0]    te;
  logic [CW-1:0]    base_t;
  logic [7:0]       base_n;

  // Next-state: frame/row sequencing, then strobes for the upcoming t.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    r_d      = r_q;
    rowadd_d = rowadd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tlast_d  = tlast_q;
    t2_d     = t2_q;
    t3_d     = t3_q;
    t4_d     = t4_q;
    t5_d     = t5_q;
    t6_d     = t6_q;
    nrow_d   = nrow_q;
    stride_d = stride_q;
    unique case (state_q)
      IDLE: begin
        if (bus.trigger_i) begin
          if (bus.NUM_ROW != '0) begin
            tlast_d  = (bus.T1 == '0) ? '0 : bus.T1 - T_ONE;
            t2_d     = bus.T2;
            t3_d     = bus.T3;
            t4_d     = bus.T4;
            t5_d     = bus.T5;
            t6_d     = bus.T6;
            nrow_d   = bus.NUM_ROW;
            stride_d = bus.ROW_STRIDE;
            rowadd_d = bus.ROW_START;
            state_d  = ROW;
            busy_d   = 1'b1;
            r_d      = '0;
            t_d      = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ROW: begin
        if (t_q == tlast_q) begin
          t_d = '0;
          if (r_q == nrow_q - R_ONE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            r_d      = r_q + R_ONE;
            rowadd_d = rowadd_q + stride_q;
          end
        end else begin
          t_d = t_q + T_ONE;
        end
      end
      default: ;
    endcase

    // Latched copies are already in the _d values on the trigger cycle,
    // so the first row's t=0 strobes come out together with re_busy.
    run    = (state_d == ROW);
    te     = CW'(t_d);
    start  = run && (t_d == '0);
    base_t = start ? CW'(t5_d) : pend_q;
    base_n = start ? 8'(N_MUX) : left_q;
    hit    = run && (base_n != '0) && (te == base_t);

    col_l_d = run && (te < CW'(t2_d));
    prech_d = run && (te < CW'(t3_d));
    mux_d   = run && (te >= CW'(t5_d))
                  && (te < CW'(t5_d) + CW'(t4_d));
    cp_d    = hit;
    pend_d  = hit ? base_t + CW'(t6_d) : base_t;
    left_d  = hit ? ((t6_d == '0) ? 8'd0 : base_n - 8'd1)
                  : base_n;
`ifdef RO_FRAME_CNT_EN
    fcnt_d  = fcnt_q + {15'd0, done_d};
`endif
  end

  // Single state/output register bank; reset aborts any frame silently.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      t_q      <= '0;
      r_q      <= '0;
      rowadd_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tlast_q  <= '0;
      t2_q     <= '0;
      t3_q     <= '0;
      t4_q     <= '0;
      t5_q     <= '0;
      t6_q     <= '0;
      nrow_q   <= '0;
      stride_q <= '0;
      col_l_q  <= 1'b0;
      prech_q  <= 1'b0;
      mux_q    <= 1'b0;
      cp_q     <= 1'b0;
      pend_q   <= '0;
      left_q   <= '0;
`ifdef RO_FRAME_CNT_EN
      fcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      r_q      <= r_d;
      rowadd_q <= rowadd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tlast_q  <= tlast_d;
      t2_q     <= t2_d;
      t3_q     <= t3_d;
      t4_q     <= t4_d;
      t5_q     <= t5_d;
      t6_q     <= t6_d;
      nrow_q   <= nrow_d;
      stride_q <= stride_d;
      col_l_q  <= col_l_d;
      prech_q  <= prech_d;
      mux_q    <= mux_d;
      cp_q     <= cp_d;
      pend_q   <= pend_d;
      left_q   <= left_d;
`ifdef RO_FRAME_CNT_EN
      fcnt_q   <= fcnt_d;
`endif
    end
  end

  assign bus.re_busy    = busy_q;
  assign bus.ROWADD     = rowadd_q;
  assign bus.COL_L_EN   = col_l_q;
  assign bus.COL_PRECH  = prech_q;
  assign bus.MUX_START  = mux_q;
  assign bus.CP_MUX_IN  = cp_q;
  assign bus.frame_done = done_q;
`ifdef RO_FRAME_CNT_EN
  assign bus.frame_cnt  = fcnt_q;
`endif
endmodule

// File: tb/tb_readout_seq_v2.sv
// Bench for readout_seq_v2: frame-level arithmetic model, per-cycle checks.
// Covers frame_cnt as well when RO_FRAME_CNT_EN is defined.
module tb_readout_seq_v2;
  localparam int ROW_W = 10;
  localparam int TW    = 16;
  localparam int N_MUX = 4;

  typedef logic [ROW_W+5:0] vec_t;
  typedef struct {
    int t1; int t2; int t3; int t4; int t5; int t6;
    int nrow; int start; int stride;
  } cfg_t;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   last_row = 0;
  int   fcnt = 0;
  int   seen[$];

  readout_seq_v2_if #(.ROW_W(ROW_W), .TW(TW)) bus ();

  readout_seq_v2 #(.ROW_W(ROW_W), .TW(TW), .N_MUX(N_MUX)) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  function automatic cfg_t mk(input int t1, t2, t3, t4, t5, t6,
                              input int nrow, start, stride);
    cfg_t c;
    c.t1 = t1; c.t2 = t2; c.t3 = t3; c.t4 = t4; c.t5 = t5;
    c.t6 = t6; c.nrow = nrow; c.start = start; c.stride = stride;
    return c;
  endfunction

  // Expected outputs j cycles after the trigger was sampled.
  function automatic vec_t model(input cfg_t c, input int j,
                                 input int prev);
    int t1e, len, t, r, row, last;
    logic busy, done, cl, pc, ms, cp;
    t1e = (c.t1 == 0) ? 1 : c.t1;
    len = c.nrow * t1e;
    last = (c.nrow > 0) ?
      (c.start + (c.nrow - 1) * c.stride) % (1 << ROW_W) : prev;
    busy = 0; done = 0; cl = 0; pc = 0; ms = 0; cp = 0;
    row = last;
    if (j < len) begin
      r = j / t1e;
      t = j % t1e;
      busy = 1;
      row = (c.start + r * c.stride) % (1 << ROW_W);
      cl = (t < c.t2);
      pc = (t < c.t3);
      ms = (t >= c.t5) && (t < c.t5 + c.t4);
      for (int k = 0; k < N_MUX; k++)
        if (!(c.t6 == 0 && k > 0) && t == c.t5 + k * c.t6) cp = 1;
    end else if (j == len) begin
      done = 1;
    end
    return {busy, done, cl, pc, ms, cp, row[ROW_W-1:0]};
  endfunction

  function automatic vec_t observed();
    return {bus.re_busy, bus.frame_done, bus.COL_L_EN, bus.COL_PRECH,
            bus.MUX_START, bus.CP_MUX_IN, bus.ROWADD};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input cfg_t c);
    bus.T1 = c.t1[TW-1:0];
    bus.T2 = c.t2[TW-1:0];
    bus.T3 = c.t3[TW-1:0];
    bus.T4 = c.t4[TW-1:0];
    bus.T5 = c.t5[TW-1:0];
    bus.T6 = c.t6[TW-1:0];
    bus.NUM_ROW = c.nrow[ROW_W:0];
    bus.ROW_START = c.start[ROW_W-1:0];
    bus.ROW_STRIDE = c.stride[ROW_W-1:0];
  endtask

  task automatic scramble();
    cfg_t c;
    c = mk($urandom_range(0, 60), $urandom_range(0, 60),
           $urandom_range(0, 60), $urandom_range(0, 60),
           $urandom_range(0, 60), $urandom_range(0, 60),
           $urandom_range(1, 30), $urandom_range(0, 1023),
           $urandom_range(0, 1023));
    drive(c);
  endtask

  task automatic chk_cnt(input string tag, input int exp_c);
`ifdef RO_FRAME_CNT_EN
    check(tag, 32'(bus.frame_cnt), 32'(exp_c & 16'hFFFF));
`else
    if (exp_c < 0) $display("unused %s", tag);
`endif
  endtask

  // One frame; retrig_j/rst_j >= 0 inject a trigger or a reset there.
  task automatic run_frame(input string name, input cfg_t c,
                           input int retrig_j, input int rst_j);
    int t1e, len;
    t1e = (c.t1 == 0) ? 1 : c.t1;
    len = c.nrow * t1e;
    seen.delete();
    @(negedge CLK);
    drive(c);
    bus.trigger_i = 1'b1;
    for (int j = 0; j <= len + 1; j++) begin
      @(negedge CLK);
      bus.trigger_i = 1'b0;
      scramble();
      check($sformatf("%s_j%0d", name, j), 32'(observed()),
            32'(model(c, j, last_row)));
      chk_cnt($sformatf("%s_cnt_j%0d", name, j),
              fcnt + ((j >= len) ? 1 : 0));
      if (j < len && (j % t1e) == 0) seen.push_back(int'(bus.ROWADD));
      if (j == retrig_j) bus.trigger_i = 1'b1;
      if (j == rst_j) begin
        #2 rst = 1'b1;
        #1 check({name, "_async_rst"}, 32'(observed()), 32'd0);
        chk_cnt({name, "_async_rst_cnt"}, 0);
        @(negedge CLK);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge CLK);
          check($sformatf("%s_post_rst%0d", name, k),
                32'(observed()), 32'd0);
        end
        last_row = 0;
        fcnt = 0;
        return;
      end
    end
    fcnt++;
    if (c.nrow > 0)
      last_row = (c.start + (c.nrow - 1) * c.stride) % (1 << ROW_W);
  endtask

  initial begin
    cfg_t c;
    int   exp_rows[4];
    bus.trigger_i = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    #50;
    check("reset_state", 32'(observed()), 32'd0);
    chk_cnt("reset_cnt", 0);
    #50 rst = 1'b0;

    // Nominal frame; T6=0 leaves only the first mux pulse.
    run_frame("nominal", mk(1724, 862, 2, 3, 2, 0, 20, 0, 1), -1, -1);

    // Four mux pulses per row, then clipped to three by T1=50.
    run_frame("mux4", mk(100, 10, 1, 3, 2, 20, 2, 7, 1), -1, -1);
    run_frame("mux_clip", mk(50, 10, 1, 3, 2, 20, 2, 7, 1), -1, -1);

    // Row address wrap.
    run_frame("wrap", mk(3, 1, 1, 1, 0, 1, 4, 1020, 3), -1, -1);
    exp_rows = '{1020, 1023, 2, 5};
    check("wrap_rows", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      check($sformatf("wrap_row%0d", i), 32'(seen[i]),
            32'(exp_rows[i]));

    // Re-trigger while busy is ignored; NUM_ROW=0 only pulses done.
    run_frame("retrig", mk(10, 4, 2, 2, 1, 3, 5, 100, 9), 17, -1);
    run_frame("zero_rows", mk(10, 4, 2, 2, 1, 3, 0, 55, 9), -1, -1);

    // Zero widths, T1=0 and windows past the row end.
    run_frame("zero_w", mk(6, 0, 0, 0, 0, 2, 3, 10, 1), -1, -1);
    run_frame("t1_zero", mk(0, 1, 1, 1, 0, 0, 5, 3, 2), -1, -1);
    run_frame("clip", mk(5, 9, 9, 9, 3, 1, 3, 0, 500), -1, -1);

    // Reset in row 5 of 20, then a clean restart.
    c = mk(8, 3, 2, 2, 1, 2, 20, 300, 4);
    run_frame("rst_mid", c, -1, 5 * 8 + 3);
    run_frame("after_rst", c, -1, -1);

    // Randomized frames.
    for (int n = 0; n < 25; n++) begin
      int len1;
      c = mk($urandom_range(0, 30), 0, 0, 0, 0,
             $urandom_range(0, 12), $urandom_range(0, 5),
             $urandom_range(0, 1023), $urandom_range(0, 1023));
      c.t2 = $urandom_range(0, c.t1 + 4);
      c.t3 = $urandom_range(0, c.t1 + 4);
      c.t4 = $urandom_range(0, c.t1 + 4);
      c.t5 = $urandom_range(0, c.t1 + 4);
      len1 = c.nrow * ((c.t1 == 0) ? 1 : c.t1);
      run_frame($sformatf("rnd%0d", n), c,
                (len1 > 1 && $urandom_range(0, 1) == 1) ?
                  $urandom_range(0, len1 - 1) : -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
